// File: rtl/wb_cfg_arbiter_pkg.sv
// Shared types for the Wishbone config arbiter.
// FSM states, latched request bundle and timeout default.
package wb_cfg_arbiter_pkg;

  localparam int WB_AW = 10;
  localparam int WB_DW = 32;
  localparam int TIMEOUT_CYC_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [3:0]       sel;
  } wb_req_s;

endpackage

// File: rtl/wb_cfg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Registered priority pointer, combinational one-hot grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] last,
  output logic [1:0] gnt
);

  // prio=0 favours requester 0, prio=1 favours requester 1
  logic prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (upd) begin
      prio <= last[0];
    end
  end

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~prio | ~req[1]);
    gnt[1] = req[1] & (prio | ~req[0]);
  end

endmodule

// File: rtl/wb_cfg_arbiter.sv
// Single-beat Wishbone classic master shared by two requesters.
// Round-robin grant, one transaction in flight, ack/err/timeout return.
module wb_cfg_arbiter
  import wb_cfg_arbiter_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = WB_AW,
  parameter int DW          = WB_DW,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [NREQ-1:0]   rq_req_i,
  input  logic [NREQ-1:0]   rq_we_i,
  input  logic [NREQ*AW-1:0] rq_adr_i,
  input  logic [NREQ*DW-1:0] rq_dat_i,
  input  logic [NREQ*4-1:0] rq_sel_i,
  output logic [NREQ-1:0]   rq_gnt_o,
  output logic [NREQ-1:0]   rq_done_o,
  output logic              rq_err_o,
  output logic              rq_tmo_o,
  output logic [DW-1:0]     rq_rdat_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  state_e        state;
  state_e        state_nxt;
  logic [1:0]    arb_gnt;
  logic [CW-1:0] cnt;
  logic          tmo_hit;
  logic          start;
  logic          finish;
  logic          retire;
  logic          w;
  wb_req_s       pick;
  wb_req_s       cur;

  rr_arb2 u_arb (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .req   (rq_req_i),
    .upd   (retire),
    .last  (rq_gnt_o),
    .gnt   (arb_gnt)
  );

  assign w       = arb_gnt[1];
  assign tmo_hit = (cnt == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    pick     = '0;
    pick.we  = w ? rq_we_i[1] : rq_we_i[0];
    pick.adr = w ? rq_adr_i[2*AW-1:AW] : rq_adr_i[AW-1:0];
    pick.dat = w ? rq_dat_i[2*DW-1:DW] : rq_dat_i[DW-1:0];
    pick.sel = w ? rq_sel_i[7:4] : rq_sel_i[3:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|rq_req_i) begin
          start     = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i | wb_err_i | tmo_hit) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // err wins over ack; neither means the counter expired
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cur       <= '0;
      cnt       <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      rq_gnt_o  <= '0;
      rq_done_o <= '0;
      rq_err_o  <= 1'b0;
      rq_tmo_o  <= 1'b0;
      rq_rdat_o <= '0;
    end else begin
      if (start) begin
        rq_gnt_o <= arb_gnt;
        cur      <= pick;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        cnt      <= '0;
      end
      if (state == BUS) begin
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
        cur       <= '0;
        wb_cyc_o  <= 1'b0;
        wb_stb_o  <= 1'b0;
        rq_done_o <= rq_gnt_o;
        rq_err_o  <= wb_err_i | ~wb_ack_i;
        rq_tmo_o  <= ~wb_err_i & ~wb_ack_i;
        rq_rdat_o <= (wb_ack_i & ~wb_err_i & ~cur.we) ? wb_dat_i : '0;
      end
      if (retire) begin
        rq_gnt_o  <= '0;
        rq_done_o <= '0;
        rq_err_o  <= 1'b0;
        rq_tmo_o  <= 1'b0;
        rq_rdat_o <= '0;
      end
    end
  end

  assign wb_adr_o = cur.adr;
  assign wb_dat_o = cur.dat;
  assign wb_sel_o = cur.sel;
  assign wb_we_o  = cur.we;

endmodule

// File: tb/tb_wb_cfg_arbiter.sv
// Directed bench for wb_cfg_arbiter with a 16-cycle timeout.
// Slave responses are driven by hand from the stimulus sequence.
module tb_wb_cfg_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rq_req;
  logic [1:0]    rq_we;
  logic [2*AW-1:0] rq_adr;
  logic [2*DW-1:0] rq_dat;
  logic [7:0]    rq_sel;
  logic [1:0]    rq_gnt;
  logic [1:0]    rq_done;
  logic          rq_err;
  logic          rq_tmo;
  logic [DW-1:0] rq_rdat;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_stb;
  logic [DW-1:0] s_dat;
  logic          s_ack;
  logic          s_err;

  int nchk;
  int nfail;
  int n;

  wb_cfg_arbiter #(
    .NREQ        (2),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .rq_req_i   (rq_req),
    .rq_we_i    (rq_we),
    .rq_adr_i   (rq_adr),
    .rq_dat_i   (rq_dat),
    .rq_sel_i   (rq_sel),
    .rq_gnt_o   (rq_gnt),
    .rq_done_o  (rq_done),
    .rq_err_o   (rq_err),
    .rq_tmo_o   (rq_tmo),
    .rq_rdat_o  (rq_rdat),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat),
    .wb_sel_o   (wb_sel),
    .wb_we_o    (wb_we),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_dat_i   (s_dat),
    .wb_ack_i   (s_ack),
    .wb_err_i   (s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nchk   = 0;
    nfail  = 0;
    rst_n  = 1'b0;
    rq_req = '0;
    rq_we  = '0;
    rq_adr = '0;
    rq_dat = '0;
    rq_sel = '0;
    s_dat  = '0;
    s_ack  = 1'b0;
    s_err  = 1'b0;

    tick;
    tick;
    chk("rst_ctl", 64'({wb_cyc, wb_stb, wb_we}), 64'h0);
    chk("rst_gnt", 64'({rq_gnt, rq_done}), 64'h0);
    chk("rst_rsp", 64'({rq_err, rq_tmo, rq_rdat}), 64'h0);
    chk("rst_bus", 64'({wb_adr, wb_sel}), 64'h0);
    rst_n = 1'b1;
    tick;

    // single write from requester 0
    rq_req = 2'b01;
    rq_we  = 2'b01;
    rq_adr[AW-1:0] = 10'h000;
    rq_dat[DW-1:0] = 32'h0000_A423;
    rq_sel[3:0] = 4'hF;
    tick;
    chk("wr_ctl", 64'({wb_cyc, wb_stb, wb_we}), 64'h7);
    chk("wr_gnt", 64'(rq_gnt), 64'h1);
    chk("wr_bus", 64'({wb_adr, wb_sel}), 64'({10'h000, 4'hF}));
    chk("wr_dat", 64'(wb_dat), 64'h0000_A423);
    tick;
    chk("wr_hold", 64'({wb_cyc, wb_stb, wb_dat}), 64'({2'b11, 32'h0000_A423}));
    s_ack = 1'b1;
    tick;
    s_ack  = 1'b0;
    rq_req = 2'b00;
    chk("wr_done", 64'({rq_done, rq_err, rq_tmo}), 64'({2'b01, 2'b00}));
    chk("wr_drop", 64'({wb_cyc, wb_stb}), 64'h0);
    chk("wr_rdat", 64'(rq_rdat), 64'h0);
    tick;
    chk("wr_idle", 64'({rq_gnt, rq_done}), 64'h0);

    // read from requester 1; request dropped while granted
    rq_req = 2'b10;
    rq_we  = 2'b00;
    rq_adr[2*AW-1:AW] = 10'h100;
    rq_sel[7:4] = 4'hF;
    tick;
    rq_req = 2'b00;
    chk("rd_gnt", 64'(rq_gnt), 64'h2);
    chk("rd_bus", 64'({wb_adr, wb_we, wb_cyc}), 64'({10'h100, 1'b0, 1'b1}));
    s_dat = 32'hDEAD_BEEF;
    s_ack = 1'b1;
    tick;
    s_ack = 1'b0;
    chk("rd_done", 64'({rq_done, rq_err}), 64'({2'b10, 1'b0}));
    chk("rd_rdat", 64'(rq_rdat), 64'hDEAD_BEEF);
    tick;
    chk("rd_idle", 64'({rq_gnt, rq_rdat}), 64'h0);

    // both requesting: strict alternation starting with 0
    rq_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("alt_gnt", 64'(rq_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("alt_cyc", 64'(wb_cyc), 64'h1);
      s_ack = 1'b1;
      tick;
      s_ack = 1'b0;
      chk("alt_done", 64'(rq_done), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick;
      chk("alt_gap", 64'({wb_cyc, wb_stb, rq_gnt}), 64'h0);
    end
    rq_req = 2'b00;

    // err together with ack on a read
    rq_req = 2'b01;
    rq_adr[AW-1:0] = 10'h004;
    tick;
    rq_req = 2'b00;
    s_dat = 32'h1234_5678;
    s_ack = 1'b1;
    s_err = 1'b1;
    tick;
    s_ack = 1'b0;
    s_err = 1'b0;
    chk("err_done", 64'({rq_done, rq_err, rq_tmo}), 64'({2'b01, 2'b10}));
    chk("err_rdat", 64'(rq_rdat), 64'h0);
    tick;

    // stray ack/err while idle
    s_ack = 1'b1;
    s_err = 1'b1;
    tick;
    tick;
    s_ack = 1'b0;
    s_err = 1'b0;
    chk("stray", 64'({rq_gnt, rq_done, rq_err, wb_cyc}), 64'h0);

    // async reset mid-BUS; pointer favours 1 before reset
    rq_req = 2'b11;
    tick;
    chk("rst_pre", 64'(rq_gnt), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", 64'({wb_cyc, wb_stb}), 64'h0);
    chk("arst_gnt", 64'({rq_gnt, rq_done}), 64'h0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_post", 64'(rq_gnt), 64'h1);
    s_ack = 1'b1;
    rq_req = 2'b00;
    tick;
    s_ack = 1'b0;
    chk("rst_done", 64'(rq_done), 64'h1);
    tick;

    // timeout: no response for requester 1 write
    rq_req = 2'b10;
    rq_we  = 2'b10;
    tick;
    rq_req = 2'b00;
    n = wb_stb ? 1 : 0;
    while (wb_stb && n < 40) begin
      tick;
      if (wb_stb) n++;
    end
    chk("tmo_len", 64'(n), 64'd16);
    chk("tmo_done", 64'({rq_done, rq_err, rq_tmo}), 64'({2'b10, 2'b11}));
    tick;
    chk("tmo_idle", 64'({rq_gnt, rq_done, rq_err, rq_tmo}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
